// File: rtl/kcpsm_port_bank.sv
// PicoBlaze I/O port bank: byte-staged output words with atomic commit, synchronised switch
// inputs and a change interrupt. Define KCPSM_PORT_BANK_DEBOUNCE_EN to add per-bit debouncing.
module kcpsm_port_word #(
  parameter int WORD_BYTES = 2
) (
  input  logic                    CLK1,
  input  logic                    arst,
  input  logic                    wr,
  input  logic [1:0]              b,
  input  logic [7:0]              din,
  output logic [WORD_BYTES*8-1:0] word_q,
  output logic                    commit,
  output logic                    pending
);
  localparam logic [1:0] TOP = 2'(WORD_BYTES-1);

  generate
    if (WORD_BYTES == 1) begin : g_direct
      always_ff @(posedge CLK1) begin
        if (arst) begin
          word_q <= '0;
          commit <= 1'b0;
        end else begin
          commit <= wr;
          if (wr) word_q <= din;
        end
      end
      assign pending = 1'b0;
    end else begin : g_staged
      logic [WORD_BYTES-2:0][7:0] staging;
      // staging survives a commit so a later write of the top byte alone re-commits
      always_ff @(posedge CLK1) begin
        if (arst) begin
          staging <= '0;
          word_q  <= '0;
          commit  <= 1'b0;
          pending <= 1'b0;
        end else begin
          commit <= 1'b0;
          if (wr) begin
            if (b == TOP) begin
              word_q  <= {din, staging};
              commit  <= 1'b1;
              pending <= 1'b0;
            end else begin
              for (int j = 0; j < WORD_BYTES-1; j++)
                if (b == 2'(j)) staging[j] <= din;
              pending <= 1'b1;
            end
          end
        end
      end
    end
  endgenerate
endmodule

module kcpsm_port_bank #(
  parameter int NUM_OUT    = 2,
  parameter int WORD_BYTES = 2,
  parameter int SW_W       = 8,
  parameter int DB_CYCLES  = 16
) (
  input  logic                            CLK1,
  input  logic                            arst,
  input  logic [7:0]                      port_id,
  input  logic                            write_strobe,
  input  logic                            read_strobe,
  input  logic [7:0]                      out_port,
  output logic [7:0]                      in_port,
  output logic                            interrupt,
  input  logic                            interrupt_ack,
  input  logic [SW_W-1:0]                 sw,
  output logic [NUM_OUT*WORD_BYTES*8-1:0] words_out,
  output logic [NUM_OUT-1:0]              commit
);
  localparam logic [1:0] TOP_B = 2'(WORD_BYTES-1);

  generate
    if (NUM_OUT < 1 || NUM_OUT > 8 || WORD_BYTES < 1 || WORD_BYTES > 4 ||
        SW_W < 1 || SW_W > 8 || DB_CYCLES < 2) begin : g_bad_param
      $error("kcpsm_port_bank: parameter out of range");
    end
  endgenerate

  logic [NUM_OUT-1:0][WORD_BYTES*8-1:0] word_q;
  logic [NUM_OUT-1:0]                   pending;
  logic                                 wr_win;

  assign wr_win = write_strobe && port_id[7:5] == 3'b000 && port_id[1:0] <= TOP_B;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_word
      kcpsm_port_word #(.WORD_BYTES(WORD_BYTES)) u_word (
        .CLK1    (CLK1),
        .arst    (arst),
        .wr      (wr_win && port_id[4:2] == 3'(gi)),
        .b       (port_id[1:0]),
        .din     (out_port),
        .word_q  (word_q[gi]),
        .commit  (commit[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

  assign words_out = word_q;

  logic [SW_W-1:0] sw_s1, sw_s2, sw_stable, sw_prev;
  logic            irq_en, changed, sw_change;

  always_ff @(posedge CLK1) begin
    if (arst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

`ifdef KCPSM_PORT_BANK_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  logic [SW_W-1:0][CW-1:0] db_cnt;

  // a bit must disagree with sw_stable for DB_CYCLES consecutive edges before it is accepted
  always_ff @(posedge CLK1) begin
    if (arst) begin
      db_cnt    <= '0;
      sw_stable <= '0;
    end else begin
      for (int i = 0; i < SW_W; i++) begin
        if (sw_s2[i] != sw_stable[i]) begin
          if (db_cnt[i] == CW'(DB_CYCLES-1)) begin
            sw_stable[i] <= sw_s2[i];
            db_cnt[i]    <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign sw_stable = sw_s2;
`endif

  assign sw_change = |(sw_stable ^ sw_prev);

  // a change landing in the same cycle as a clear (status read or ack) wins
  always_ff @(posedge CLK1) begin
    if (arst) begin
      sw_prev   <= '0;
      irq_en    <= 1'b0;
      changed   <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      sw_prev <= sw_stable;
      if (write_strobe && port_id == 8'h40) irq_en <= out_port[0];
      if (sw_change) changed <= 1'b1;
      else if (read_strobe && port_id == 8'h81) changed <= 1'b0;
      if (sw_change && irq_en) interrupt <= 1'b1;
      else if (interrupt_ack) interrupt <= 1'b0;
    end
  end

  always_comb begin
    in_port = '0;
    case (port_id)
      8'h80:   in_port = 8'(sw_stable);
      8'h81:   in_port = {changed, interrupt, irq_en, 5'b0};
      8'h82:   in_port = 8'(pending);
      default: in_port = '0;
    endcase
  end
endmodule
